// File: rtl/rv32_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
package rv32_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } seq_state_t;

   localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam logic [1:0] PC_SEL_INIT   = 2'b10;

   localparam logic [3:0] ALU_OP_ILLEGAL = 4'b1111;

   function automatic logic is_mem_access(input logic mem_to_reg, input logic mem_write);
      return mem_to_reg | mem_write;
   endfunction

endpackage

// File: rtl/seq_perf_counter.sv
// Free-running performance counters for the sequencer: active cycles and retired instructions.
module seq_perf_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        active,
   input  logic        retire,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (active) cycle_cnt   <= cycle_cnt + 32'd1;
         if (retire) instret_cnt <= instret_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM around the shared decoder/ALU/regfile datapath.
// Optional PERF_CNT_EN adds cycle_cnt / instret_cnt outputs via seq_perf_counter.
//
// state  | meaning
// IDLE   | waiting for run; pc_sel points at pc_init
// FETCH  | imem_req held until imem_ack or timeout
// DECODE | capture decoder controls, trap illegal opcode
// EXEC   | resolve branch, or steer to MEM / WB
// MEM    | dmem_req held until dmem_ack or timeout
// WB     | register-file write, advance PC
// HALT   | sticky stop until rst
//
// All outputs are flops: a strobe decided in a state (often on an ack) is
// visible in the following cycle, aligned with the state just entered.
module multicycle_sequencer
   import rv32_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic        dec_mem_to_reg,
   input  logic        dec_mem_write,
   input  logic        dec_branch,
   input  logic        dec_we_reg,
   input  logic [3:0]  dec_alu_op,
   input  logic        br_taken,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic [31:0] pc_init,
   output logic        rf_we,
   output logic        wb_sel_mem,
   output logic        halted,
   output logic [2:0]  state_o
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   // Wait timer counts down from MEM_TIMEOUT-1; reaching zero without ack ends the wait.
   localparam int unsigned     TMR_W    = $clog2(MEM_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

   seq_state_t       state;
   logic [TMR_W-1:0] tmr;
   logic             lat_mem_to_reg;
   logic             lat_mem_write;
   logic             lat_branch;
   logic             lat_we_reg;

   assign pc_init = RESET_PC;
   assign state_o = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         tmr            <= '0;
         imem_req       <= 1'b0;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         ir_we          <= 1'b0;
         pc_we          <= 1'b0;
         rf_we          <= 1'b0;
         pc_sel         <= PC_SEL_INIT;
         wb_sel_mem     <= 1'b0;
         halted         <= 1'b0;
         lat_mem_to_reg <= 1'b0;
         lat_mem_write  <= 1'b0;
         lat_branch     <= 1'b0;
         lat_we_reg     <= 1'b0;
      end else begin
         ir_we <= 1'b0;
         pc_we <= 1'b0;
         rf_we <= 1'b0;
         case (state)
            IDLE: begin
               pc_sel <= PC_SEL_INIT;
               if (run) begin
                  pc_we    <= 1'b1;
                  imem_req <= 1'b1;
                  tmr      <= TMR_LOAD;
                  state    <= FETCH;
               end
            end
            FETCH: begin
               if (imem_ack) begin
                  ir_we    <= 1'b1;
                  imem_req <= 1'b0;
                  state    <= DECODE;
               end else if (tmr == '0) begin
                  imem_req <= 1'b0;
                  halted   <= 1'b1;
                  state    <= HALT;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            DECODE: begin
               lat_mem_to_reg <= dec_mem_to_reg;
               lat_mem_write  <= dec_mem_write;
               lat_branch     <= dec_branch;
               lat_we_reg     <= dec_we_reg;
               if (dec_alu_op == ALU_OP_ILLEGAL) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (lat_branch) begin
                  pc_we    <= 1'b1;
                  pc_sel   <= br_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                  imem_req <= 1'b1;
                  tmr      <= TMR_LOAD;
                  state    <= FETCH;
               end else if (is_mem_access(lat_mem_to_reg, lat_mem_write)) begin
                  dmem_req <= 1'b1;
                  dmem_we  <= lat_mem_write;
                  tmr      <= TMR_LOAD;
                  state    <= MEM;
               end else begin
                  state <= WB;
               end
            end
            MEM: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (lat_mem_write) begin
                     pc_we    <= 1'b1;
                     pc_sel   <= PC_SEL_PLUS4;
                     imem_req <= 1'b1;
                     tmr      <= TMR_LOAD;
                     state    <= FETCH;
                  end else begin
                     state <= WB;
                  end
               end else if (tmr == '0) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  halted   <= 1'b1;
                  state    <= HALT;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            WB: begin
               rf_we      <= lat_we_reg;
               wb_sel_mem <= lat_mem_to_reg;
               pc_we      <= 1'b1;
               pc_sel     <= PC_SEL_PLUS4;
               imem_req   <= 1'b1;
               tmr        <= TMR_LOAD;
               state      <= FETCH;
            end
            HALT: begin
               halted <= 1'b1;
            end
            default: begin
               halted <= 1'b1;
               state  <= HALT;
            end
         endcase
      end
   end

`ifdef PERF_CNT_EN
   // The IDLE launch pulse is the only pc_we that carries PC_SEL_INIT, so it is excluded here.
   seq_perf_counter u_perf (
      .clk         (clk),
      .rst         (rst),
      .active      ((state != IDLE) && (state != HALT)),
      .retire      (pc_we && (pc_sel != PC_SEL_INIT)),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: instruction-level timing model feeds
// expected strobe events and request lengths; a monitor compares what the DUT presents.
module tb_multicycle_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_1000;
   localparam int          MT     = 16;

   typedef enum logic [1:0] {K_ALU, K_BR, K_LD, K_ST} kind_t;
   typedef struct {kind_t kind; int fw; int mw; logic we; logic br; logic [3:0] op;} instr_t;
   typedef struct {int cyc; logic ir; logic pc; logic rf; logic [1:0] sel; logic wb; bit chk_sel; bit chk_wb;} ev_t;
   typedef struct {int len; logic we;} dacc_t;

   logic        clk = 1'b0;
   logic        rst, run, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
   logic        dec_mem_to_reg, dec_mem_write, dec_branch, dec_we_reg, br_taken;
   logic [3:0]  dec_alu_op;
   logic        ir_we, pc_we, rf_we, wb_sel_mem, halted;
   logic [1:0]  pc_sel;
   logic [31:0] pc_init;
   logic [2:0]  state_o;
`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   multicycle_sequencer #(.RESET_PC(RST_PC), .MEM_TIMEOUT(MT)) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .imem_req       (imem_req),
      .imem_ack       (imem_ack),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_ack       (dmem_ack),
      .dec_mem_to_reg (dec_mem_to_reg),
      .dec_mem_write  (dec_mem_write),
      .dec_branch     (dec_branch),
      .dec_we_reg     (dec_we_reg),
      .dec_alu_op     (dec_alu_op),
      .br_taken       (br_taken),
      .ir_we          (ir_we),
      .pc_we          (pc_we),
      .pc_sel         (pc_sel),
      .pc_init        (pc_init),
      .rf_we          (rf_we),
      .wb_sel_mem     (wb_sel_mem),
      .halted         (halted),
      .state_o        (state_o)
`ifdef PERF_CNT_EN
      ,
      .cycle_cnt      (cycle_cnt),
      .instret_cnt    (instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   ev_t   ev_q[$];
   int    imem_q[$];
   dacc_t dmem_q[$];

   int    total = 0, bad = 0, cyc = 0, t_fetch = 0;
   int    ilen = 0, dlen = 0, exp_len = 0;
   logic  dwe_first = 1'b0;
   bit    dwe_var = 1'b0, ev_ok = 1'b0;
   logic  p_ir = 1'b0, p_pc = 1'b0, p_rf = 1'b0;
   ev_t   e_cur;
   dacc_t d_cur;
   instr_t dir_tbl[7];
   instr_t cur;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: one sample per cycle, 1 time unit after the rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            ilen = 0; dlen = 0; p_ir = 1'b0; p_pc = 1'b0; p_rf = 1'b0;
         end else begin
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
               e_cur = ev_q.pop_front();
               total++; bad++;
               $display("FAIL missing_strobe cyc=%0d actual=none required ir/pc/rf=%b%b%b", e_cur.cyc, e_cur.ir, e_cur.pc, e_cur.rf);
            end
            if (ir_we || pc_we || rf_we) begin
               total++;
               if (ev_q.size() == 0 || ev_q[0].cyc != cyc) begin
                  bad++;
                  $display("FAIL unexpected_strobe cyc=%0d actual ir/pc/rf=%b%b%b required none", cyc, ir_we, pc_we, rf_we);
               end else begin
                  e_cur = ev_q.pop_front();
                  ev_ok = (ir_we === e_cur.ir) && (pc_we === e_cur.pc) && (rf_we === e_cur.rf)
                          && (!e_cur.chk_sel || pc_sel === e_cur.sel) && (!e_cur.chk_wb || wb_sel_mem === e_cur.wb)
                          && !(ir_we && p_ir) && !(pc_we && p_pc) && !(rf_we && p_rf);
                  if (!ev_ok) begin
                     bad++;
                     $display("FAIL strobe_event cyc=%0d actual ir/pc/rf=%b%b%b sel=%b wb=%b prev=%b%b%b required ir/pc/rf=%b%b%b sel=%b wb=%b prev=000",
                              cyc, ir_we, pc_we, rf_we, pc_sel, wb_sel_mem, p_ir, p_pc, p_rf,
                              e_cur.ir, e_cur.pc, e_cur.rf, e_cur.sel, e_cur.wb);
                  end
               end
            end
            if (imem_req === 1'b1) begin
               ilen++;
            end else if (ilen > 0) begin
               total++;
               exp_len = (imem_q.size() > 0) ? imem_q.pop_front() : 0;
               if (ilen != exp_len) begin
                  bad++;
                  $display("FAIL imem_req_len actual=%0d required=%0d", ilen, exp_len);
               end
               ilen = 0;
            end
            if (dmem_req === 1'b1) begin
               if (dlen == 0) begin
                  dwe_first = dmem_we; dwe_var = 1'b0;
               end else if (dmem_we !== dwe_first) begin
                  dwe_var = 1'b1;
               end
               dlen++;
            end else if (dlen > 0) begin
               total++;
               d_cur = (dmem_q.size() > 0) ? dmem_q.pop_front() : '{0, 1'b0};
               if (dlen != d_cur.len || dwe_first !== d_cur.we || dwe_var) begin
                  bad++;
                  $display("FAIL dmem_req_len actual=%0d we=%b varied=%0d required=%0d we=%b", dlen, dwe_first, dwe_var, d_cur.len, d_cur.we);
               end
               dlen = 0;
            end
            p_ir = ir_we; p_pc = pc_we; p_rf = rf_we;
         end
      end
   end

   task automatic do_fetch(input int fw);
      int n = 0;
      while (imem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (imem_req !== 1'b1) begin
         total++; bad++;
         $display("FAIL imem_req_wait actual=0 required=1");
         return;
      end
      repeat (fw) @(negedge clk);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
   endtask

   task automatic do_mem(input int mw);
      int n = 0;
      while (dmem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (dmem_req !== 1'b1) begin
         total++; bad++;
         $display("FAIL dmem_req_wait actual=0 required=1");
         return;
      end
      repeat (mw) @(negedge clk);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
   endtask

   // Called on a negedge with rst low: FETCH begins next cycle.
   task automatic launch();
      run = 1'b1;
      t_fetch = cyc + 1;
      ev_q.push_back('{t_fetch, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0});
   endtask

   task automatic set_decoder(input instr_t p);
      dec_mem_to_reg = (p.kind == K_LD);
      dec_mem_write  = (p.kind == K_ST);
      dec_branch     = (p.kind == K_BR);
      dec_we_reg     = p.we;
      dec_alu_op     = p.op;
      br_taken       = p.br;
   endtask

   // Reference timing: fetch takes fw+1 cycles, decode 1, exec 1, mem mw+1, wb 1.
   // The instruction's closing pc_we is seen in the first cycle of the next fetch.
   task automatic run_instr(input instr_t p);
      int  ta, te;
      bit  is_mem, writes;
      is_mem = (p.kind == K_LD) || (p.kind == K_ST);
      writes = (p.kind == K_ALU) || (p.kind == K_LD);
      set_decoder(p);
      ta = t_fetch + p.fw;
      case (p.kind)
         K_BR:    te = ta + 3;
         K_ALU:   te = ta + 4;
         K_ST:    te = ta + 4 + p.mw;
         default: te = ta + 5 + p.mw;
      endcase
      ev_q.push_back('{ta + 1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
      ev_q.push_back('{te, 1'b0, 1'b1, writes ? p.we : 1'b0, (p.kind == K_BR) ? {1'b0, p.br} : 2'b00,
                       (p.kind == K_LD), 1'b1, writes});
      imem_q.push_back(p.fw + 1);
      if (is_mem) dmem_q.push_back('{p.mw + 1, (p.kind == K_ST)});
      do_fetch(p.fw);
      if (is_mem) do_mem(p.mw);
      else repeat (2) @(negedge clk);
      t_fetch = te;
   endtask

   task automatic wait_halt(input string name, input int exp_cyc);
      int n = 0;
      while (halted !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      check(name, (halted === 1'b1) ? cyc : -1, exp_cyc);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_state", state_o, 3'd0);
      check("rst_halted", halted, 1'b0);
      check("rst_reqs", {imem_req, dmem_req, dmem_we}, 3'b000);
      check("rst_strobes", {ir_we, pc_we, rf_we}, 3'b000);
      check("rst_pc_sel", pc_sel, 2'b10);
      rst = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      dec_mem_to_reg = 1'b0; dec_mem_write = 1'b0; dec_branch = 1'b0;
      dec_we_reg = 1'b0; dec_alu_op = 4'd0; br_taken = 1'b0;
      dir_tbl[0] = '{K_ALU, 0, 0, 1'b1, 1'b0, 4'd0};
      dir_tbl[1] = '{K_BR, 0, 0, 1'b1, 1'b1, 4'd8};
      dir_tbl[2] = '{K_LD, 0, 3, 1'b1, 1'b0, 4'd0};
      dir_tbl[3] = '{K_ST, 0, 0, 1'b1, 1'b0, 4'd0};
      dir_tbl[4] = '{K_ALU, 15, 0, 1'b0, 1'b0, 4'd3};
      dir_tbl[5] = '{K_LD, 1, 15, 1'b1, 1'b0, 4'd0};
      dir_tbl[6] = '{K_BR, 2, 0, 1'b0, 1'b0, 4'd9};

      repeat (3) @(negedge clk);
      check("rst_pc_init", pc_init, RST_PC);
      do_reset();

      // Directed and random instruction stream, ended by a fetch that is never acked.
      launch();
      foreach (dir_tbl[i]) run_instr(dir_tbl[i]);
      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 3);
         cur.kind = (k == 0) ? K_ALU : (k == 1) ? K_BR : (k == 2) ? K_LD : K_ST;
         cur.fw   = $urandom_range(0, 3);
         cur.mw   = $urandom_range(0, 3);
         cur.we   = 1'($urandom_range(0, 1));
         cur.br   = 1'($urandom_range(0, 1));
         cur.op   = 4'($urandom_range(0, 14));
         run_instr(cur);
         run = 1'($urandom_range(0, 1));
      end
      imem_q.push_back(MT);
      wait_halt("fetch_timeout_cycle", t_fetch + MT);
      check("fetch_timeout_state", state_o, 3'd6);
      check("fetch_timeout_req", imem_req, 1'b0);
      repeat (6) begin run = ~run; @(negedge clk); end
      check("halt_sticky", {halted, state_o, imem_req}, {1'b1, 3'd6, 1'b0});
      do_reset();

      // Illegal opcode traps in DECODE; run toggling afterwards is ignored.
      launch();
      cur = '{K_ALU, 1, 0, 1'b1, 1'b0, 4'b1111};
      set_decoder(cur);
      ev_q.push_back('{t_fetch + 2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
      imem_q.push_back(2);
      do_fetch(1);
      wait_halt("illegal_halt_cycle", t_fetch + 3);
      repeat (8) begin run = ~run; @(negedge clk); end
      check("illegal_sticky", {halted, state_o, imem_req, dmem_req}, {1'b1, 3'd6, 1'b0, 1'b0});
      do_reset();

      // Load whose data access is never acked.
      launch();
      cur = '{K_LD, 0, 0, 1'b1, 1'b0, 4'd0};
      set_decoder(cur);
      ev_q.push_back('{t_fetch + 1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
      imem_q.push_back(1);
      dmem_q.push_back('{MT, 1'b0});
      do_fetch(0);
      wait_halt("mem_timeout_cycle", t_fetch + 3 + MT);
      check("mem_timeout_req", {dmem_req, dmem_we, rf_we}, 3'b000);
      do_reset();

      // Reset in the middle of a store's data wait.
      launch();
      cur = '{K_ST, 0, 0, 1'b0, 1'b0, 4'd0};
      set_decoder(cur);
      ev_q.push_back('{t_fetch + 1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
      imem_q.push_back(1);
      do_fetch(0);
      begin
         int n = 0;
         while (dmem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      end
      check("mid_mem_req_seen", {dmem_req, dmem_we}, 2'b11);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run = 1'b0;
      @(negedge clk);
      check("mid_mem_rst_req", {dmem_req, dmem_we, imem_req}, 3'b000);
      check("mid_mem_rst_strobes", {ir_we, pc_we, rf_we}, 3'b000);
      check("mid_mem_rst_state", state_o, 3'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_holds", {state_o, imem_req}, {3'd0, 1'b0});

      check("events_drained", ev_q.size(), 0);
      check("imem_drained", imem_q.size(), 0);
      check("dmem_drained", dmem_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
